// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and issue bundle between the decoder/ROB side and
// the ALU reservation-station scheduler.
interface alu_rs_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 32,
    parameter int TAG_W  = 4,
    parameter int VAL_W  = 32
);
    logic              dis_valid;
    logic              dis_ready;
    logic [INST_W-1:0] dis_inst;
    logic [ADDR_W-1:0] dis_npc;
    logic [IMM_W-1:0]  dis_imme;
    logic [TAG_W-1:0]  dis_tag;
    logic              dis_rs1_busy;
    logic              dis_rs2_busy;
    logic [TAG_W-1:0]  dis_rs1_tag;
    logic [TAG_W-1:0]  dis_rs2_tag;
    logic [VAL_W-1:0]  dis_rs1_val;
    logic [VAL_W-1:0]  dis_rs2_val;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [VAL_W-1:0]  cdb_val;

    logic              alu_valid;
    logic [INST_W-1:0] alu_inst;
    logic [ADDR_W-1:0] alu_npc;
    logic [VAL_W-1:0]  alu_rs1_val;
    logic [VAL_W-1:0]  alu_rs2_val;
    logic [IMM_W-1:0]  alu_imme;
    logic [TAG_W-1:0]  alu_tag;

    modport master (
        output dis_valid, dis_inst, dis_npc, dis_imme, dis_tag,
               dis_rs1_busy, dis_rs2_busy, dis_rs1_tag, dis_rs2_tag,
               dis_rs1_val, dis_rs2_val,
               cdb_valid, cdb_tag, cdb_val,
        input  dis_ready,
               alu_valid, alu_inst, alu_npc, alu_rs1_val, alu_rs2_val,
               alu_imme, alu_tag
    );

    modport slave (
        input  dis_valid, dis_inst, dis_npc, dis_imme, dis_tag,
               dis_rs1_busy, dis_rs2_busy, dis_rs1_tag, dis_rs2_tag,
               dis_rs1_val, dis_rs2_val,
               cdb_valid, cdb_tag, cdb_val,
        output dis_ready,
               alu_valid, alu_inst, alu_npc, alu_rs1_val, alu_rs2_val,
               alu_imme, alu_tag
    );
endinterface

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: holds dispatched ops until both operands are known
// (directly or via CDB wakeup) and issues the lowest-index ready op each cycle.
module alu_rs_scheduler #(
    parameter int RS_SIZE = 8,
    parameter int INST_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int IMM_W   = 32,
    parameter int TAG_W   = 4,
    parameter int VAL_W   = 32,
    localparam int IDX_W  = $clog2(RS_SIZE),
    localparam int CNT_W  = $clog2(RS_SIZE) + 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    alu_rs_if.slave          bus,
    output logic [CNT_W-1:0] rs_count
);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [INST_W-1:0]  inst_q   [RS_SIZE];
    logic [INST_W-1:0]  inst_d   [RS_SIZE];
    logic [ADDR_W-1:0]  npc_q    [RS_SIZE];
    logic [ADDR_W-1:0]  npc_d    [RS_SIZE];
    logic [IMM_W-1:0]   imme_q   [RS_SIZE];
    logic [IMM_W-1:0]   imme_d   [RS_SIZE];
    logic [TAG_W-1:0]   dest_q   [RS_SIZE];
    logic [TAG_W-1:0]   dest_d   [RS_SIZE];
    logic [RS_SIZE-1:0] r1_rdy_q, r1_rdy_d;
    logic [RS_SIZE-1:0] r2_rdy_q, r2_rdy_d;
    logic [TAG_W-1:0]   r1_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   r1_tag_d [RS_SIZE];
    logic [TAG_W-1:0]   r2_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   r2_tag_d [RS_SIZE];
    logic [VAL_W-1:0]   r1_val_q [RS_SIZE];
    logic [VAL_W-1:0]   r1_val_d [RS_SIZE];
    logic [VAL_W-1:0]   r2_val_q [RS_SIZE];
    logic [VAL_W-1:0]   r2_val_d [RS_SIZE];

    logic               alu_valid_q, alu_valid_d;
    logic [INST_W-1:0]  alu_inst_q, alu_inst_d;
    logic [ADDR_W-1:0]  alu_npc_q, alu_npc_d;
    logic [VAL_W-1:0]   alu_rs1_q, alu_rs1_d;
    logic [VAL_W-1:0]   alu_rs2_q, alu_rs2_d;
    logic [IMM_W-1:0]   alu_imme_q, alu_imme_d;
    logic [TAG_W-1:0]   alu_tag_q, alu_tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               issue_found_s;
    logic [IDX_W-1:0]   issue_idx_s;
    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;
    logic               dis_ready_s;
    logic               dis_fire_s;
    logic               dis_r1_hit_s;
    logic               dis_r2_hit_s;

    // Readiness depends only on the registered count, never on this cycle's issue.
    assign dis_ready_s = (cnt_q < CNT_W'(RS_SIZE));

    // Priority pick of the lowest-index ready entry and lowest-index free entry.
    always_comb begin
        issue_found_s = 1'b0;
        issue_idx_s   = '0;
        free_found_s  = 1'b0;
        free_idx_s    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (busy_q[i] && r1_rdy_q[i] && r2_rdy_q[i]) begin
                issue_found_s = 1'b1;
                issue_idx_s   = IDX_W'(i);
            end else begin
                issue_found_s = issue_found_s;
            end
            if (!busy_q[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Next-state for entries, issue bundle and occupancy count.
    always_comb begin
        busy_d      = busy_q;
        inst_d      = inst_q;
        npc_d       = npc_q;
        imme_d      = imme_q;
        dest_d      = dest_q;
        r1_rdy_d    = r1_rdy_q;
        r2_rdy_d    = r2_rdy_q;
        r1_tag_d    = r1_tag_q;
        r2_tag_d    = r2_tag_q;
        r1_val_d    = r1_val_q;
        r2_val_d    = r2_val_q;
        alu_valid_d = alu_valid_q;
        alu_inst_d  = alu_inst_q;
        alu_npc_d   = alu_npc_q;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        alu_imme_d  = alu_imme_q;
        alu_tag_d   = alu_tag_q;
        cnt_d       = cnt_q;
        dis_fire_s  = 1'b0;
        dis_r1_hit_s = bus.cdb_valid && (bus.cdb_tag == bus.dis_rs1_tag);
        dis_r2_hit_s = bus.cdb_valid && (bus.cdb_tag == bus.dis_rs2_tag);

        if (!rdy_in) begin
            dis_fire_s = 1'b0;
        end else if (flush_in) begin
            busy_d      = '0;
            alu_valid_d = 1'b0;
            cnt_d       = '0;
        end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (bus.cdb_valid && busy_q[i] && !r1_rdy_q[i] && (r1_tag_q[i] == bus.cdb_tag)) begin
                    r1_rdy_d[i] = 1'b1;
                    r1_val_d[i] = bus.cdb_val;
                end else begin
                    r1_rdy_d[i] = r1_rdy_q[i];
                end
                if (bus.cdb_valid && busy_q[i] && !r2_rdy_q[i] && (r2_tag_q[i] == bus.cdb_tag)) begin
                    r2_rdy_d[i] = 1'b1;
                    r2_val_d[i] = bus.cdb_val;
                end else begin
                    r2_rdy_d[i] = r2_rdy_q[i];
                end
            end

            // The issued entry is already fully ready, so wakeup never collides with it.
            alu_valid_d = issue_found_s;
            if (issue_found_s) begin
                busy_d[issue_idx_s] = 1'b0;
                alu_inst_d          = inst_q[issue_idx_s];
                alu_npc_d           = npc_q[issue_idx_s];
                alu_rs1_d           = r1_val_q[issue_idx_s];
                alu_rs2_d           = r2_val_q[issue_idx_s];
                alu_imme_d          = imme_q[issue_idx_s];
                alu_tag_d           = dest_q[issue_idx_s];
            end else begin
                alu_tag_d = alu_tag_q;
            end

            dis_fire_s = bus.dis_valid && dis_ready_s && free_found_s;
            if (dis_fire_s) begin
                busy_d[free_idx_s]   = 1'b1;
                inst_d[free_idx_s]   = bus.dis_inst;
                npc_d[free_idx_s]    = bus.dis_npc;
                imme_d[free_idx_s]   = bus.dis_imme;
                dest_d[free_idx_s]   = bus.dis_tag;
                r1_tag_d[free_idx_s] = bus.dis_rs1_tag;
                r2_tag_d[free_idx_s] = bus.dis_rs2_tag;
                r1_rdy_d[free_idx_s] = !bus.dis_rs1_busy || dis_r1_hit_s;
                r2_rdy_d[free_idx_s] = !bus.dis_rs2_busy || dis_r2_hit_s;
                r1_val_d[free_idx_s] = bus.dis_rs1_busy ? bus.cdb_val : bus.dis_rs1_val;
                r2_val_d[free_idx_s] = bus.dis_rs2_busy ? bus.cdb_val : bus.dis_rs2_val;
            end else begin
                busy_d[free_idx_s] = busy_d[free_idx_s];
            end

            case ({dis_fire_s, issue_found_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State registers; asynchronous reset clears entries and the issue bundle.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q      <= '0;
            r1_rdy_q    <= '0;
            r2_rdy_q    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                inst_q[i]   <= '0;
                npc_q[i]    <= '0;
                imme_q[i]   <= '0;
                dest_q[i]   <= '0;
                r1_tag_q[i] <= '0;
                r2_tag_q[i] <= '0;
                r1_val_q[i] <= '0;
                r2_val_q[i] <= '0;
            end
            alu_valid_q <= 1'b0;
            alu_inst_q  <= '0;
            alu_npc_q   <= '0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_imme_q  <= '0;
            alu_tag_q   <= '0;
            cnt_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            r1_rdy_q    <= r1_rdy_d;
            r2_rdy_q    <= r2_rdy_d;
            inst_q      <= inst_d;
            npc_q       <= npc_d;
            imme_q      <= imme_d;
            dest_q      <= dest_d;
            r1_tag_q    <= r1_tag_d;
            r2_tag_q    <= r2_tag_d;
            r1_val_q    <= r1_val_d;
            r2_val_q    <= r2_val_d;
            alu_valid_q <= alu_valid_d;
            alu_inst_q  <= alu_inst_d;
            alu_npc_q   <= alu_npc_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_imme_q  <= alu_imme_d;
            alu_tag_q   <= alu_tag_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.dis_ready   = dis_ready_s;
    assign bus.alu_valid   = alu_valid_q;
    assign bus.alu_inst    = alu_inst_q;
    assign bus.alu_npc     = alu_npc_q;
    assign bus.alu_rs1_val = alu_rs1_q;
    assign bus.alu_rs2_val = alu_rs2_q;
    assign bus.alu_imme    = alu_imme_q;
    assign bus.alu_tag     = alu_tag_q;
    assign rs_count        = cnt_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench: stimulus pushes expected issue bundles, an independent monitor
// pops and compares them whenever alu_valid is presented.
module tb_alu_rs_scheduler;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] npc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imme;
        logic [3:0]  tag;
    } exp_t;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       rdy_in;
    logic       flush_in;
    logic [3:0] rs_count;
    logic       rdy_edge = 1'b0;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    alu_rs_if bus ();

    alu_rs_scheduler #(.RS_SIZE(8)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .bus      (bus),
        .rs_count (rs_count)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) rdy_edge <= rdy_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every fresh issue must match the oldest expected bundle.
    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in && rdy_edge && bus.alu_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL issue_unexpected: got tag %0d expected no issue at %0t", bus.alu_tag, $time);
            end else begin
                e = exp_q.pop_front();
                chk("alu_inst", 64'(bus.alu_inst), 64'(e.inst));
                chk("alu_npc",  64'(bus.alu_npc),  64'(e.npc));
                chk("alu_rs1",  64'(bus.alu_rs1_val), 64'(e.rs1));
                chk("alu_rs2",  64'(bus.alu_rs2_val), 64'(e.rs2));
                chk("alu_imme", 64'(bus.alu_imme), 64'(e.imme));
                chk("alu_tag",  64'(bus.alu_tag),  64'(e.tag));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        bus.dis_valid = 1'b0;
        bus.cdb_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = tag;
        bus.cdb_val   = val;
    endtask

    task automatic dis(input logic [31:0] inst, input logic [31:0] npc, input logic [31:0] imme,
                       input logic [3:0] tag,
                       input logic b1, input logic [3:0] t1, input logic [31:0] v1,
                       input logic b2, input logic [3:0] t2, input logic [31:0] v2);
        bus.dis_valid    = 1'b1;
        bus.dis_inst     = inst;
        bus.dis_npc      = npc;
        bus.dis_imme     = imme;
        bus.dis_tag      = tag;
        bus.dis_rs1_busy = b1;
        bus.dis_rs1_tag  = t1;
        bus.dis_rs1_val  = v1;
        bus.dis_rs2_busy = b2;
        bus.dis_rs2_tag  = t2;
        bus.dis_rs2_val  = v2;
    endtask

    task automatic expect_issue(input logic [31:0] inst, input logic [31:0] npc,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imme, input logic [3:0] tag);
        exp_t e;
        e.inst = inst; e.npc = npc; e.rs1 = rs1; e.rs2 = rs2; e.imme = imme; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 30 && exp_q.size() != 0; k++) step();
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_in   = 1'b0;
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        dis(32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        cdb(4'd0, 32'd0);
        idle();
        repeat (2) step();
        chk("reset_count", 64'(rs_count), 64'd0);
        chk("reset_valid", 64'(bus.alu_valid), 64'd0);
        chk("reset_tag", 64'(bus.alu_tag), 64'd0);
        rst_in = 1'b1;
        chk("ready_after_reset", 64'(bus.dis_ready), 64'd1);

        // addi with ready operand issues one edge after dispatch
        dis(32'h00308093, 32'h104, 32'd3, 4'd2, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd0);
        expect_issue(32'h00308093, 32'h104, 32'd5, 32'd0, 32'd3, 4'd2);
        step(); idle();
        chk("t1_count_in", 64'(rs_count), 64'd1);
        step();
        chk("t1_count_out", 64'(rs_count), 64'd0);
        step();
        chk("t1_valid_pulse", 64'(bus.alu_valid), 64'd0);

        // waiting operand woken by CDB, issues the cycle after
        dis(32'h002081b3, 32'h108, 32'd0, 4'd5, 1'b1, 4'd4, 32'hdead, 1'b0, 4'd0, 32'd1);
        step(); idle();
        repeat (2) step();
        chk("t2_wait_count", 64'(rs_count), 64'd1);
        chk("t2_no_early_issue", 64'(bus.alu_valid), 64'd0);
        cdb(4'd4, 32'h10);
        step(); idle();
        chk("t2_capture_edge", 64'(bus.alu_valid), 64'd0);
        expect_issue(32'h002081b3, 32'h108, 32'h10, 32'd1, 32'd0, 4'd5);
        step();
        chk("t2_count_out", 64'(rs_count), 64'd0);

        // same-cycle CDB bypass into dispatch
        cdb(4'd4, 32'd7);
        dis(32'h00c50533, 32'h10c, 32'd0, 4'd6, 1'b0, 4'd0, 32'd9, 1'b1, 4'd4, 32'hbeef);
        expect_issue(32'h00c50533, 32'h10c, 32'd9, 32'd7, 32'd0, 4'd6);
        step(); idle();
        chk("t3_count_in", 64'(rs_count), 64'd1);
        step();
        chk("t3_count_out", 64'(rs_count), 64'd0);

        // dispatch and issue in the same cycle keep the count
        dis(32'h33, 32'h200, 32'd1, 4'd3, 1'b0, 4'd0, 32'h11, 1'b0, 4'd0, 32'h22);
        expect_issue(32'h33, 32'h200, 32'h11, 32'h22, 32'd1, 4'd3);
        step();
        dis(32'h34, 32'h204, 32'd2, 4'd7, 1'b0, 4'd0, 32'h44, 1'b0, 4'd0, 32'h55);
        expect_issue(32'h34, 32'h204, 32'h44, 32'h55, 32'd2, 4'd7);
        step(); idle();
        chk("t5_count_same", 64'(rs_count), 64'd1);
        step();
        chk("t5_count_out", 64'(rs_count), 64'd0);

        // fill all entries waiting on tag 1
        for (int i = 0; i < 8; i++) begin
            dis(32'h100 + 32'(i), 32'h300 + 32'(4 * i), 32'(i), 4'(8 + i),
                1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'(i));
            step();
        end
        idle();
        chk("t4_full_count", 64'(rs_count), 64'd8);
        chk("t4_full_ready", 64'(bus.dis_ready), 64'd0);
        dis(32'h777, 32'h3f0, 32'd0, 4'd0, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd1);
        step(); idle();
        chk("t4_overflow_drop", 64'(rs_count), 64'd8);
        cdb(4'd1, 32'h55);
        for (int i = 0; i < 8; i++)
            expect_issue(32'h100 + 32'(i), 32'h300 + 32'(4 * i), 32'h55, 32'(i), 32'(i), 4'(8 + i));
        step(); idle();
        chk("t4_after_wake", 64'(rs_count), 64'd8);
        step();
        chk("t4_first_issue_count", 64'(rs_count), 64'd7);
        chk("t4_ready_again", 64'(bus.dis_ready), 64'd1);
        wait_drain();
        chk("t4_empty", 64'(rs_count), 64'd0);

        // flush beats dispatch and clears occupied entries
        for (int i = 0; i < 3; i++) begin
            dis(32'h400 + 32'(i), 32'h500, 32'd0, 4'(10 + i), 1'b1, 4'd7, 32'd0, 1'b0, 4'd0, 32'd0);
            step();
        end
        idle();
        chk("t6_count3", 64'(rs_count), 64'd3);
        flush_in = 1'b1;
        dis(32'h999, 32'h600, 32'd0, 4'd13, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        step();
        flush_in = 1'b0;
        idle();
        chk("t6_flush_count", 64'(rs_count), 64'd0);
        chk("t6_flush_valid", 64'(bus.alu_valid), 64'd0);
        cdb(4'd7, 32'd1);
        step(); idle();
        repeat (2) step();
        chk("t6_no_ghost", 64'(rs_count), 64'd0);

        // rdy_in low freezes everything, including CDB, flush and dispatch
        dis(32'h500, 32'h400, 32'd4, 4'd14, 1'b1, 4'd9, 32'd0, 1'b0, 4'd0, 32'd2);
        step();
        dis(32'h501, 32'h404, 32'd5, 4'd15, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h77);
        expect_issue(32'h501, 32'h404, 32'h66, 32'h77, 32'd5, 4'd15);
        step(); idle();
        chk("t7_count2", 64'(rs_count), 64'd2);
        rdy_in   = 1'b0;
        flush_in = 1'b1;
        cdb(4'd9, 32'haa);
        dis(32'h502, 32'h408, 32'd0, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t7_frozen_count", 64'(rs_count), 64'd2);
            chk("t7_frozen_valid", 64'(bus.alu_valid), 64'd0);
        end
        rdy_in   = 1'b1;
        flush_in = 1'b0;
        idle();
        step();
        chk("t7_resume_count", 64'(rs_count), 64'd1);
        cdb(4'd9, 32'h33);
        expect_issue(32'h500, 32'h400, 32'h33, 32'd2, 32'd4, 4'd14);
        step(); idle();
        step();
        chk("t7_count_out", 64'(rs_count), 64'd0);

        // asynchronous reset mid-stream
        dis(32'h600, 32'h700, 32'd0, 4'd3, 1'b1, 4'd12, 32'd0, 1'b0, 4'd0, 32'd0);
        step(); idle();
        chk("t8_count1", 64'(rs_count), 64'd1);
        #3;
        rst_in = 1'b0;
        #1;
        chk("t8_async_tag", 64'(bus.alu_tag), 64'd0);
        chk("t8_async_valid", 64'(bus.alu_valid), 64'd0);
        chk("t8_async_count", 64'(rs_count), 64'd0);
        chk("t8_async_rs1", 64'(bus.alu_rs1_val), 64'd0);
        chk("t8_async_npc", 64'(bus.alu_npc), 64'd0);
        #1;
        rst_in = 1'b1;
        step();
        chk("t8_ready_release", 64'(bus.dis_ready), 64'd1);
        cdb(4'd12, 32'd5);
        step(); idle();
        step();
        chk("t8_discarded", 64'(rs_count), 64'd0);
        dis(32'h601, 32'h704, 32'd8, 4'd9, 1'b0, 4'd0, 32'h99, 1'b0, 4'd0, 32'h98);
        expect_issue(32'h601, 32'h704, 32'h99, 32'h98, 32'd8, 4'd9);
        step(); idle();
        chk("t8_count_in", 64'(rs_count), 64'd1);
        step();
        chk("t8_count_out", 64'(rs_count), 64'd0);

        wait_drain();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
